// File: rtl/ones_counter.sv
// ones_counter: two-stage pipelined population count.
// Stage 1 registers a 4-bit count for each 8-bit group of in_vec; stage 2
// registers the sum of those group counts. A valid bit travels alongside
// the data, so one result is produced per accepted input, in order.
// An input captured on clock edge N is presented on count/out_valid after
// edge N+1, i.e. two clock edges after the cycle in which it was driven.
module ones_counter #(
  parameter int inCount  = 32,
  parameter int outCount = $clog2(inCount)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [inCount-1:0]  in_vec,
  output logic                out_valid,
  output logic [outCount:0]   count
);

  localparam int NumGroups = (inCount + 7) / 8;
  localparam int PadW      = NumGroups * 8;
  localparam int SumW      = outCount + 1;

  // Population count of one 8-bit group; result is 0..8, so 4 bits suffice.
  function automatic logic [3:0] popcnt8(input logic [7:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'd0, v[i]};
    end
    return c;
  endfunction

  // Zero-padded copy of the input so the top group is always a full byte.
  logic [PadW-1:0] vec_pad_s;
  assign vec_pad_s = PadW'(in_vec);

  logic [3:0]      grp_d [NumGroups];
  logic [3:0]      grp_q [NumGroups];
  logic            v1_q;
  logic [SumW-1:0] sum_d;
  logic [SumW-1:0] count_q;
  logic            out_valid_q;

  // Per-group popcount of the incoming vector (stage-1 next state).
  always_comb begin
    for (int g = 0; g < NumGroups; g++) begin
      grp_d[g] = popcnt8(vec_pad_s[g*8 +: 8]);
    end
  end

  // Stage 1: capture group counts only for valid inputs so idle-cycle data
  // (including unknown bits) never reaches the pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0;
      for (int g = 0; g < NumGroups; g++) begin
        grp_q[g] <= 4'd0;
      end
    end else begin
      v1_q <= in_valid;
      if (in_valid) begin
        for (int g = 0; g < NumGroups; g++) begin
          grp_q[g] <= grp_d[g];
        end
      end else begin
        for (int g = 0; g < NumGroups; g++) begin
          grp_q[g] <= grp_q[g];
        end
      end
    end
  end

  // Sum of all group counts; SumW bits hold inCount exactly, so no overflow.
  always_comb begin
    sum_d = '0;
    for (int g = 0; g < NumGroups; g++) begin
      sum_d = sum_d + SumW'(grp_q[g]);
    end
  end

  // Stage 2: load the sum when stage 1 held a valid input, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= v1_q;
      if (v1_q) begin
        count_q <= sum_d;
      end else begin
        count_q <= count_q;
      end
    end
  end

  assign count     = count_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_ones_counter.sv
// Testbench for ones_counter: scoreboard of expected counts pushed at drive
// time and popped by a monitor whenever out_valid is seen, with the arrival
// cycle checked against the two-edge latency.
module tb_ones_counter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_vec = 32'd0;
  logic        out_valid;
  logic [5:0]  count;

  logic        in_valid12 = 1'b0;
  logic [11:0] in_vec12 = 12'd0;
  logic        out_valid12;
  logic [4:0]  count12;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [5:0] cnt;
    int         due;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  ones_counter #(.inCount(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_vec(in_vec),
    .out_valid(out_valid), .count(count)
  );

  ones_counter #(.inCount(12)) dut12 (
    .clk(clk), .rst(rst), .in_valid(in_valid12), .in_vec(in_vec12),
    .out_valid(out_valid12), .count(count12)
  );

  always #5 clk = ~clk;

  // Cycle counter used to time-stamp expected arrivals.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every pulse must match the oldest expectation, on time.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL extra_pulse: got out_valid=1 count=%0d at cycle %0d, required no pulse", count, cyc);
      end else begin
        mon_e = sb_q.pop_front();
        checks++;
        if (count !== mon_e.cnt) begin
          failures++;
          $display("FAIL sb_count: got %0d, required %0d (cycle %0d)", count, mon_e.cnt, cyc);
        end
        checks++;
        if (cyc !== mon_e.due) begin
          failures++;
          $display("FAIL sb_latency: pulse at cycle %0d, required cycle %0d", cyc, mon_e.due);
        end
      end
    end else if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      checks++;
      failures++;
      $display("FAIL missing_pulse: got out_valid=%b at cycle %0d, required pulse with count=%0d", out_valid, cyc, sb_q[0].cnt);
      void'(sb_q.pop_front());
    end
  end

  task automatic drive(input logic v, input logic [31:0] d);
    @(posedge clk);
    #1;
    in_valid = v;
    in_vec   = d;
    if (v && !rst) sb_q.push_back('{cnt: 6'($countones(d)), due: cyc + 2});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, $urandom);
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b1; in_vec = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
    checks++;
    if (count !== 6'd0) begin failures++; $display("FAIL reset_count: got %0d, required 0", count); end
    idle(3);
    @(negedge clk);
    checks++;
    if (count !== 6'd0) begin failures++; $display("FAIL reset_ignored_input: got count %0d, required 0", count); end
  endtask

  task automatic test_directed();
    logic [31:0] vecs [4];
    vecs[0] = 32'h0000_0000;
    vecs[1] = 32'hFFFF_FFFF;
    vecs[2] = 32'h8000_0001;
    vecs[3] = 32'hA5A5_A5A5;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, vecs[i]);
      idle(2);
    end
    idle(1);
    @(negedge clk);
    checks++;
    if (count !== 6'd16) begin failures++; $display("FAIL directed_hold: got count %0d, required 16", count); end
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL directed_idle_valid: got %b, required 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) drive(1'b1, $urandom);
    idle(3);
    checks++;
    if (sb_q.size() != 0) begin failures++; $display("FAIL b2b_drain: got %0d pending, required 0", sb_q.size()); end
  endtask

  task automatic test_idle_gating();
    drive(1'b1, 32'h0000_000F);
    for (int i = 0; i < 5; i++) drive(1'b0, 32'hFFFF_FFFF);
    @(negedge clk);
    checks++;
    if (count !== 6'd4) begin failures++; $display("FAIL gating_count: got %0d, required 4", count); end
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL gating_valid: got %b, required 0", out_valid); end
  endtask

  task automatic test_reset_flush();
    drive(1'b1, 32'hFFFF_0000);
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0;
    sb_q.delete();
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b1; in_vec = 32'h0000_0001;
    sb_q.push_back('{cnt: 6'd1, due: cyc + 2});
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_valid: got %b, required 0", out_valid); end
    checks++;
    if (count !== 6'd0) begin failures++; $display("FAIL flush_count: got %0d, required 0", count); end
    idle(2);
    @(negedge clk);
    checks++;
    if (count !== 6'd1) begin failures++; $display("FAIL flush_restart: got %0d, required 1", count); end
  endtask

  task automatic test_width12();
    logic [11:0] vecs [2];
    logic [4:0]  exps [2];
    vecs[0] = 12'hFFF; exps[0] = 5'd12;
    vecs[1] = 12'h801; exps[1] = 5'd2;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      in_valid12 = 1'b1; in_vec12 = vecs[i];
      @(posedge clk); #1;
      in_valid12 = 1'b0; in_vec12 = 12'hFFF;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (out_valid12 !== 1'b1) begin failures++; $display("FAIL w12_valid[%0d]: got %b, required 1", i, out_valid12); end
      checks++;
      if (count12 !== exps[i]) begin failures++; $display("FAIL w12_count[%0d]: got %0d, required %0d", i, count12, exps[i]); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1000; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom);
    end
    idle(1);
    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin failures++; $display("FAIL random_drain: got %0d pending, required 0", sb_q.size()); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_idle_gating();
    test_reset_flush();
    test_width12();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
